// File: rtl/ring_pkg.sv
// Shared constants and the routing rule for the bidirectional ring router node.
package ring_pkg;
    localparam int CW    = 0;
    localparam int CCW   = 1;
    localparam int PE    = 2;
    localparam int NPORT = 3;

    localparam int DATA_W_DEF  = 64;
    localparam int HOP_W_DEF   = 8;
    localparam int HOP_LSB_DEF = 48;
    localparam int DIR_BIT_DEF = 62;
    localparam int VC_BIT_DEF  = 63;

    // Exhausted hop count ejects locally; otherwise the direction bit picks the ring side.
    function automatic logic [1:0] route(input logic hop_zero, input logic dir);
        if (hop_zero) begin
            return 2'(PE);
        end
        return dir ? 2'(CCW) : 2'(CW);
    endfunction
endpackage

// File: rtl/rr_arb3.sv
// Three-requester round-robin arbiter; the pointer advances past the winner only on a grant.
module rr_arb3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       en,
    output logic [2:0] gnt
);
    logic [1:0] ptr;
    logic [2:0] pick;

    always_comb begin
        pick = 3'b000;
        case (ptr)
            2'd0:    pick = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
            2'd1:    pick = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            default: pick = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
        endcase
        gnt = en ? pick : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (|gnt) begin
            ptr <= gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : 2'd0;
        end
    end
endmodule

// File: rtl/ring_router_vc.sv
// Ring router node: cw/ccw/pe inputs with two phase-alternating banks each, per-output
// round-robin arbitration into a one-entry output buffer, hop-count routing and PE loopback.
module ring_router_vc
    import ring_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int HOP_W   = HOP_W_DEF,
    parameter int HOP_LSB = HOP_LSB_DEF,
    parameter int DIR_BIT = DIR_BIT_DEF,
    parameter int VC_BIT  = VC_BIT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              polarity,
    input  logic              cwsi,
    output logic              cwri,
    input  logic [DATA_W-1:0] cwdi,
    input  logic              ccwsi,
    output logic              ccwri,
    input  logic [DATA_W-1:0] ccwdi,
    input  logic              pesi,
    output logic              peri,
    input  logic [DATA_W-1:0] pedi,
    output logic              cwso,
    input  logic              cwro,
    output logic [DATA_W-1:0] cwdo,
    output logic              ccwso,
    input  logic              ccwro,
    output logic [DATA_W-1:0] ccwdo,
    output logic              peso,
    input  logic              pero,
    output logic [DATA_W-1:0] pedo
);
    // Link handshake: a beat transfers at the clock edge where send and ready are both high;
    // ready depends on state only, and send/data stay put until that edge.
    logic [NPORT-1:0]  si, ri, ro, free, taken;
    logic [DATA_W-1:0] di [NPORT];
    logic [DATA_W-1:0] cap [NPORT];
    logic [1:0]        dest [NPORT];
    logic [1:0]        ibuf_valid [NPORT];
    logic [DATA_W-1:0] ibuf_data [NPORT][2];
    logic [NPORT-1:0]  obuf_valid;
    logic [DATA_W-1:0] obuf_data [NPORT];
    logic [NPORT-1:0]  req [NPORT];
    logic [NPORT-1:0]  gnt [NPORT];
    logic [DATA_W-1:0] win_data [NPORT];

    assign si = {pesi, ccwsi, cwsi};
    assign ro = {pero, ccwro, cwro};
    assign di[CW]  = cwdi;
    assign di[CCW] = ccwdi;
    assign di[PE]  = pedi;

    assign cwri  = ri[CW];
    assign ccwri = ri[CCW];
    assign peri  = ri[PE];
    assign cwso  = obuf_valid[CW];
    assign ccwso = obuf_valid[CCW];
    assign peso  = obuf_valid[PE];
    assign cwdo  = obuf_data[CW];
    assign ccwdo = obuf_data[CCW];
    assign pedo  = obuf_data[PE];

    // The bank matching the phase receives; the opposite bank competes for outputs.
    always_comb begin
        for (int x = 0; x < NPORT; x++) begin
            ri[x]  = ~ibuf_valid[x][polarity];
            cap[x] = di[x];
            if (x != PE) begin
                cap[x][HOP_LSB +: HOP_W] = di[x][HOP_LSB +: HOP_W] - HOP_W'(1);
            end
            dest[x] = route(ibuf_data[x][~polarity][HOP_LSB +: HOP_W] == '0,
                            ibuf_data[x][~polarity][DIR_BIT]);
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            free[o] = ~obuf_valid[o] | ro[o];
            for (int x = 0; x < NPORT; x++) begin
                req[o][x] = ibuf_valid[x][~polarity] && (dest[x] == 2'(o));
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arb3 u_arb (
            .clk (CLK),
            .rst (RST),
            .req (req[o]),
            .en  (free[o]),
            .gnt (gnt[o])
        );
    end

    always_comb begin
        taken = '0;
        for (int o = 0; o < NPORT; o++) begin
            win_data[o] = '0;
            for (int x = 0; x < NPORT; x++) begin
                if (gnt[o][x]) begin
                    win_data[o] = ibuf_data[x][~polarity];
                    taken[x]    = 1'b1;
                end
            end
            win_data[o][VC_BIT] = ~polarity;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            polarity   <= 1'b0;
            obuf_valid <= '0;
            for (int x = 0; x < NPORT; x++) begin
                ibuf_valid[x]   <= 2'b00;
                ibuf_data[x][0] <= '0;
                ibuf_data[x][1] <= '0;
                obuf_data[x]    <= '0;
            end
        end else begin
            polarity <= ~polarity;
            for (int x = 0; x < NPORT; x++) begin
                if (si[x] && ri[x]) begin
                    ibuf_valid[x][polarity] <= 1'b1;
                    ibuf_data[x][polarity]  <= cap[x];
                end
                if (taken[x]) begin
                    ibuf_valid[x][~polarity] <= 1'b0;
                end
            end
            // A refill takes priority over the drain so a draining slot is reloaded in place.
            for (int o = 0; o < NPORT; o++) begin
                if (|gnt[o]) begin
                    obuf_valid[o] <= 1'b1;
                    obuf_data[o]  <= win_data[o];
                end else if (ro[o]) begin
                    obuf_valid[o] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ring_router_vc.sv
// Bench for ring_router_vc: directed scenarios plus random traffic against a routing model.
module tb_ring_router_vc;
    localparam int DW = 64;
    localparam int HL = 48;
    localparam int DB = 62;
    localparam int VB = 63;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          polarity;
    logic [2:0]    si, ri, so, ro;
    logic [DW-1:0] di [3];
    logic [DW-1:0] dout [3];

    always #5 clk = ~clk;

    ring_router_vc dut (
        .CLK(clk), .RST(rst), .polarity(polarity),
        .cwsi(si[0]), .cwri(ri[0]), .cwdi(di[0]),
        .ccwsi(si[1]), .ccwri(ri[1]), .ccwdi(di[1]),
        .pesi(si[2]), .peri(ri[2]), .pedi(di[2]),
        .cwso(so[0]), .cwro(ro[0]), .cwdo(dout[0]),
        .ccwso(so[1]), .ccwro(ro[1]), .ccwdo(dout[1]),
        .peso(so[2]), .pero(ro[2]), .pedo(dout[2])
    );

    int            n_err = 0;
    int            n_chk = 0;
    logic [DW-1:0] snd_q [3][$];
    logic [DW-1:0] exp_q [3][$];
    logic [DW-1:0] got_cw [$];
    logic [2:0]    pres;
    logic          ro_rand;
    logic [2:0]    ro_val;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        check(tag, 64'(obs), 64'(expv));
    endtask

    // Model: ring links consume one hop, PE injects keep theirs; VC bit is excluded here.
    function automatic logic [DW-1:0] xform(input int x, input logic [DW-1:0] d);
        logic [DW-1:0] n;
        logic [7:0]    h;
        n = d;
        h = d[HL +: 8];
        if (x != 2) h = h - 8'd1;
        n[HL +: 8] = h;
        n[VB] = 1'b0;
        return n;
    endfunction

    function automatic int dest_of(input logic [DW-1:0] n);
        if (n[HL +: 8] == 8'd0) return 2;
        return n[DB] ? 1 : 0;
    endfunction

    task automatic consume(input int o, input logic [DW-1:0] d);
        logic [DW-1:0] m;
        int hit;
        m = d;
        m[VB] = 1'b0;
        hit = -1;
        for (int i = 0; i < exp_q[o].size(); i++) begin
            if (hit < 0 && exp_q[o][i] === m) hit = i;
        end
        check($sformatf("deliver_out%0d", o), 64'(hit >= 0), 64'd1);
        if (hit >= 0) exp_q[o].delete(hit);
        if (o == 0) got_cw.push_back(m);
    endtask

    // One clock: drive from the feed queues, score this cycle's transfers, advance.
    task automatic cycle();
        logic [DW-1:0] n;
        for (int x = 0; x < 3; x++) begin
            si[x] = (snd_q[x].size() > 0);
            di[x] = si[x] ? snd_q[x][0] : {$urandom, $urandom};
        end
        for (int o = 0; o < 3; o++) begin
            ro[o] = ro_rand ? 1'($urandom_range(0, 1)) : ro_val[o];
        end
        #1;
        for (int o = 0; o < 3; o++) begin
            if (so[o] === 1'b1) begin
                // A packet loaded at an edge carries the inverse of the phase before it.
                if (!pres[o]) chk1($sformatf("vc_new_out%0d", o), dout[o][VB], polarity);
                if (ro[o]) begin
                    consume(o, dout[o]);
                    pres[o] = 1'b0;
                end else begin
                    pres[o] = 1'b1;
                end
            end else begin
                pres[o] = 1'b0;
            end
        end
        for (int x = 0; x < 3; x++) begin
            if (si[x] && ri[x] === 1'b1) begin
                n = xform(x, snd_q[x][0]);
                exp_q[dest_of(n)].push_back(n);
                void'(snd_q[x].pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            for (int x = 0; x < 3; x++) begin
                si[x] = 1'($urandom_range(0, 1));
                di[x] = {$urandom, $urandom};
            end
            ro = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        si = '0;
        ro = 3'b111;
        for (int x = 0; x < 3; x++) begin
            snd_q[x].delete();
            exp_q[x].delete();
        end
        got_cw.delete();
        pres = '0;
    endtask

    task automatic check_idle(input string tag);
        chk1({tag, "_polarity"}, polarity, 1'b0);
        check({tag, "_ri"}, 64'(ri), 64'h7);
        for (int o = 0; o < 3; o++) begin
            chk1($sformatf("%s_so%0d", tag, o), so[o], 1'b0);
            check($sformatf("%s_do%0d", tag, o), dout[o], 64'h0);
        end
    endtask

    task automatic wait_phase(input logic v);
        for (int i = 0; i < 4 && polarity !== v; i++) cycle();
    endtask

    function automatic logic [DW-1:0] with_vc(input logic [DW-1:0] d, input logic vc);
        logic [DW-1:0] r;
        r = d;
        r[VB] = vc;
        return r;
    endfunction

    logic          p_acc;
    logic [DW-1:0] bp_exp [4];
    logic [DW-1:0] pkt;
    int            id;
    int            budget;

    initial begin
        si = '0; ro = 3'b111; ro_rand = 1'b0; ro_val = 3'b111; pres = '0;
        for (int x = 0; x < 3; x++) di[x] = '0;

        // Reset with random inputs, then the phase alternates from 0.
        do_reset(2);
        check_idle("reset");
        cycle(); chk1("pol_seq1", polarity, 1'b1);
        cycle(); chk1("pol_seq2", polarity, 1'b0);
        cycle(); chk1("pol_seq3", polarity, 1'b1);

        // Ring pass-through accepted at phase 0.
        wait_phase(1'b0);
        chk1("pass_ri", ri[0], 1'b1);
        snd_q[0].push_back(64'h0003_0000_0000_00AA);
        cycle();
        chk1("pass_latency", so[0], 1'b0);
        cycle();
        chk1("pass_so", so[0], 1'b1);
        check("pass_do", dout[0], 64'h0002_0000_0000_00AA);
        cycle();
        chk1("pass_clear", so[0], 1'b0);
        check("pass_do_hold", dout[0], 64'h0002_0000_0000_00AA);

        // Eject: last hop on the ccw link lands at the PE.
        p_acc = polarity;
        snd_q[1].push_back(64'h4001_0000_0000_0055);
        cycle();
        chk1("eject_latency", so[2], 1'b0);
        cycle();
        chk1("eject_so", so[2], 1'b1);
        check("eject_do", dout[2], with_vc(64'h4000_0000_0000_0055, p_acc));
        cycle();

        // Loopback then ccw injection from the PE.
        p_acc = polarity;
        snd_q[2].push_back(64'h0000_0000_0000_0077);
        cycle(); cycle();
        chk1("loop_so", so[2], 1'b1);
        check("loop_do", dout[2], with_vc(64'h0000_0000_0000_0077, p_acc));
        cycle();
        p_acc = polarity;
        snd_q[2].push_back(64'h4003_0000_0000_0033);
        cycle(); cycle();
        chk1("inject_so", so[1], 1'b1);
        check("inject_do", dout[1], with_vc(64'h4003_0000_0000_0033, p_acc));
        cycle();
        for (int o = 0; o < 3; o++) check($sformatf("directed_left%0d", o), 64'(exp_q[o].size()), 64'd0);

        // Contention on the cw output from a fresh pointer: cw input first, pe two cycles later.
        do_reset(1);
        p_acc = polarity;
        snd_q[0].push_back(64'h0005_0000_0000_00C1);
        snd_q[2].push_back(64'h0002_0000_0000_00C2);
        cycle(); cycle();
        check("cont1_first", dout[0], with_vc(64'h0004_0000_0000_00C1, p_acc));
        cycle();
        chk1("cont1_gap", so[0], 1'b0);
        cycle();
        check("cont1_second", dout[0], with_vc(64'h0002_0000_0000_00C2, p_acc));
        cycle();
        // A lone cw-input grant moves the pointer past cw, so pe now goes first.
        p_acc = polarity;
        snd_q[0].push_back(64'h0003_0000_0000_00C3);
        cycle(); cycle();
        check("cont_single", dout[0], with_vc(64'h0002_0000_0000_00C3, p_acc));
        cycle();
        p_acc = polarity;
        snd_q[0].push_back(64'h0005_0000_0000_00C4);
        snd_q[2].push_back(64'h0002_0000_0000_00C5);
        cycle(); cycle();
        check("cont2_first", dout[0], with_vc(64'h0002_0000_0000_00C5, p_acc));
        cycle();
        chk1("cont2_gap", so[0], 1'b0);
        cycle();
        check("cont2_second", dout[0], with_vc(64'h0004_0000_0000_00C4, p_acc));
        cycle();

        // Back-pressure on the cw output for ten cycles.
        do_reset(1);
        ro_val = 3'b110;
        for (int i = 0; i < 4; i++) begin
            pkt = 64'h0002_0000_0000_0A00 | 64'(i + 1);
            snd_q[0].push_back(pkt);
            bp_exp[i] = xform(0, pkt);
        end
        cycle(); cycle();
        for (int i = 0; i < 10; i++) begin
            chk1("bp_hold_so", so[0], 1'b1);
            check("bp_hold_do", dout[0], bp_exp[0]);
            cycle();
        end
        chk1("bp_stall_ri", ri[0], 1'b0);
        check("bp_upstream_wait", 64'(snd_q[0].size()), 64'd1);
        chk1("bp_release_phase", polarity, 1'b0);
        ro_val = 3'b111;
        for (int i = 0; i < 8; i++) cycle();
        check("bp_count", 64'(got_cw.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_order%0d", i), (i < got_cw.size()) ? got_cw[i] : 'x, bp_exp[i]);
        end

        // Reset in the middle of a stall drops everything in flight.
        ro_val = 3'b110;
        for (int i = 0; i < 3; i++) snd_q[0].push_back(64'h0002_0000_0000_0B00 | 64'(i));
        for (int i = 0; i < 5; i++) cycle();
        chk1("mid_stall_so", so[0], 1'b1);
        do_reset(1);
        check_idle("mid_reset");
        ro_val = 3'b111;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("post_reset_quiet", 64'(so), 64'd0);
        end

        // Random traffic on all inputs with random output readiness.
        ro_rand = 1'b1;
        id = 1;
        for (int x = 0; x < 3; x++) begin
            for (int k = 0; k < 40; k++) begin
                pkt = {$urandom, $urandom};
                pkt[31:0]   = 32'(id);
                pkt[HL +: 8] = (x == 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(1, 3));
                pkt[VB]     = 1'b0;
                snd_q[x].push_back(pkt);
                id++;
            end
        end
        budget = 0;
        while (budget < 4000 &&
               (snd_q[0].size() + snd_q[1].size() + snd_q[2].size() +
                exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0) begin
            if (budget == 3000) ro_rand = 1'b0;
            cycle();
            budget++;
        end
        check("rand_budget", 64'(budget < 4000), 64'd1);
        for (int x = 0; x < 3; x++) check($sformatf("rand_unsent%0d", x), 64'(snd_q[x].size()), 64'd0);
        for (int o = 0; o < 3; o++) check($sformatf("rand_lost_out%0d", o), 64'(exp_q[o].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
